// File: rtl/collide_job_sequencer_if.sv
// Host/engine handshake bundle for collide_job_sequencer.
// The master side is the host plus engine model; the slave side is the sequencer.
interface collide_job_sequencer_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             start_req;
  logic             start_ack;
  logic             cs;
  logic             core_done;
  logic             core_hit;
  logic             busy;
  logic             job_done;
  logic             job_hit;
  logic             job_timeout;
  logic [CNT_W-1:0] run_count;

  modport master (
    output start_req,
    output core_done,
    output core_hit,
    input  start_ack,
    input  cs,
    input  busy,
    input  job_done,
    input  job_hit,
    input  job_timeout,
    input  run_count
  );

  modport slave (
    input  start_req,
    input  core_done,
    input  core_hit,
    output start_ack,
    output cs,
    output busy,
    output job_done,
    output job_hit,
    output job_timeout,
    output run_count
  );

endinterface

// File: rtl/collide_job_sequencer.sv
// Job sequencer for the collision engine: cs pulse, settle, done/timeout wait, report.
// Optional COLLIDE_SEQ_DONE_SYNC_EN adds a 2-flop synchronizer on core_done/core_hit.
module collide_job_sequencer #(
  parameter int unsigned CS_CYCLES = 4,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned TO_W      = 16,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned CNT_W     = 8
) (
  input logic                    clk,
  input logic                    rst,
  collide_job_sequencer_if.slave bus
);

  localparam int unsigned PhMax = (CS_CYCLES > SETTLE) ? CS_CYCLES : SETTLE;
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCsp,
    StSettle,
    StRun,
    StReport
  } state_e;

  state_e             state_q, state_d;
  logic [PhW-1:0]     ph_q, ph_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_ack_q, start_ack_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               job_done_q, job_done_d;
  logic               job_hit_q, job_hit_d;
  logic               job_timeout_q, job_timeout_d;
  logic               done_q;
  logic               done_in;
  logic               hit_in;
  logic               done_evt;

`ifdef COLLIDE_SEQ_DONE_SYNC_EN
  logic [1:0] done_sync_q;
  logic [1:0] hit_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_sync_q <= '0;
      hit_sync_q  <= '0;
    end else begin
      done_sync_q <= {done_sync_q[0], bus.core_done};
      hit_sync_q  <= {hit_sync_q[0], bus.core_hit};
    end
  end

  assign done_in = done_sync_q[1];
  assign hit_in  = hit_sync_q[1];
`else
  assign done_in = bus.core_done;
  assign hit_in  = bus.core_hit;
`endif

  // Only a rising edge counts, so a done level left over from a previous job is ignored.
  assign done_evt = done_in & ~done_q;

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    to_d          = to_q;
    cnt_d         = cnt_q;
    start_ack_d   = 1'b0;
    cs_d          = cs_q;
    busy_d        = busy_q;
    job_done_d    = 1'b0;
    job_hit_d     = job_hit_q;
    job_timeout_d = job_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_req) begin
          state_d       = StCsp;
          start_ack_d   = 1'b1;
          busy_d        = 1'b1;
          cs_d          = 1'b1;
          job_hit_d     = 1'b0;
          job_timeout_d = 1'b0;
          ph_d          = '0;
        end
      end

      StCsp: begin
        if (ph_q == PhW'(CS_CYCLES - 1)) begin
          cs_d    = 1'b0;
          ph_d    = '0;
          to_d    = '0;
          state_d = (SETTLE == 0) ? StRun : StSettle;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      StSettle: begin
        if (ph_q == PhW'(SETTLE - 1)) begin
          state_d = StRun;
          to_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      StRun: begin
        // A done edge on the last timeout cycle still reports as a hit/miss result.
        if (done_evt) begin
          state_d       = StReport;
          job_hit_d     = hit_in;
          job_timeout_d = 1'b0;
          job_done_d    = 1'b1;
          cnt_d         = cnt_q + 1'b1;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = StReport;
          job_hit_d     = 1'b0;
          job_timeout_d = 1'b1;
          job_done_d    = 1'b1;
          cnt_d         = cnt_q + 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      StReport: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        cs_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      ph_q          <= '0;
      to_q          <= '0;
      cnt_q         <= '0;
      start_ack_q   <= 1'b0;
      cs_q          <= 1'b0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      job_hit_q     <= 1'b0;
      job_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      to_q          <= to_d;
      cnt_q         <= cnt_d;
      start_ack_q   <= start_ack_d;
      cs_q          <= cs_d;
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
      job_hit_q     <= job_hit_d;
      job_timeout_q <= job_timeout_d;
      done_q        <= done_in;
    end
  end

  assign bus.start_ack   = start_ack_q;
  assign bus.cs          = cs_q;
  assign bus.busy        = busy_q;
  assign bus.job_done    = job_done_q;
  assign bus.job_hit     = job_hit_q;
  assign bus.job_timeout = job_timeout_q;
  assign bus.run_count   = cnt_q;

endmodule
